data_selector: RTL and testbench
================================

DATA_SELECTOR -- requirements
Module: data_selector

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 4, meaning the nibble (element) width in bits.
REQ-002 The module SHALL have parameter MAIN_INPUTS, default 16, meaning the number of DATA_WIDTH elements in wData.
REQ-003 The module SHALL have parameter REGS_INPUTS, default 64, meaning the number of DATA_WIDTH elements across wRegs0..wRegs7.
REQ-004 The module SHALL have parameter REGS_BITS_PER_INPUT, default 32, meaning the width of each wRegsN port.
REQ-005 The module SHALL have parameter SELECTOR_OUTPUTS, default 4, meaning the number of output buses.
REQ-006 The module SHALL have parameter SELECTOR_OUTPUTS_PER_BUS, default 4, meaning the number of selection slots per bus.
REQ-007 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-008 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-009 The module SHALL have port rst, input, 1 bit: the asynchronous, active-high reset.
REQ-010 The module SHALL have port wBusy, input, 1 bit: when 1, the output holds its value.
REQ-011 The module SHALL have port wSelec, input, 176 bits: 16 slot fields of 11 bits each; slot i occupies [11i+10:11i].
REQ-012 The module SHALL have port wData, input, 64 bits: main elements; element j = wData[4j+3:4j].
REQ-013 The module SHALL have ports wRegs0..wRegs7, input, 32 bits each: register elements; element r = wRegs(r/8)[4(r%8)+3:4(r%8)].
REQ-014 The module SHALL have port data_out, output, 16 bits: {bus3,bus2,bus1,bus0}, with bus k = data_out[4k+3:4k].
REQ-015 A netlist variant named data_selectorSynth SHALL exist with identical ports and the default parameters fixed.

Function
REQ-016 Slot field SHALL decode as: bit0 = origin (0 = main, 1 = regs); bits[4:1] = main index (0..15); bits[10:5] = reg index (0..63).
REQ-017 Slot value SHALL be the main element at the main index when origin = 0, else the reg element at the reg index; all indices are always in range.
REQ-018 Slot i SHALL belong to bus i/4; bus k SHALL be the bitwise XOR of the values of slots 4k..4k+3.
REQ-019 Field width SHALL be log2(REGS_INPUTS)+log2(MAIN_INPUTS)+1; wSelec width SHALL be that times SELECTOR_OUTPUTS*SELECTOR_OUTPUTS_PER_BUS.
REQ-020 When registered (see REQ-026), data_out SHALL update on each rising clk edge with wBusy = 0, giving 1-cycle latency from inputs.
REQ-021 When wBusy = 1 at a rising edge, data_out SHALL keep its previous value; the first edge after wBusy returns to 0 SHALL load the current selection.
REQ-022 Reset SHALL take priority over wBusy and over the clock.

Reset
REQ-023 Asserting rst SHALL force data_out to 16'h0000 immediately, without waiting for a clock edge.
REQ-024 data_out SHALL remain 0 while rst = 1.
REQ-025 After rst deasserts, the first rising edge with wBusy = 0 SHALL load the selection.

Configuration
REQ-026 With macro DATA_SELECTOR_OUTREG_EN defined, data_out SHALL be registered per REQ-020/021; without it, data_out SHALL be the combinational bus XOR, wBusy SHALL be ignored, and data_out SHALL be forced to 0 while rst = 1.

Verification
Common setup: wData = 64'h0123456789abcdef; {wRegs0..wRegs7} = 256'h6789abcd_f0123456_789abcde_f0123456_789abcde_f0123456_789abcde_f6012345 (wRegs0 most significant); macro defined.

REQ-027 Slot 4k = main index {0,1,4,14} for k = 0..3; all other slots = main 15 (value 0) -> data_out = 16'h1bef one edge later.
REQ-028 Slot 4k = origin 1, reg index {0,8,63,56}; other slots = main 15 -> data_out = 16'h5f6d.
REQ-029 Slots 0..15 = origin 0, main index i -> data_out = 16'h0000.
REQ-030 Apply REQ-027, set wBusy = 1, then change wData to 0 -> data_out holds 16'h1bef; wBusy = 0 -> next edge gives 16'h0000.
REQ-031 Assert rst between clock edges while data_out = 16'h1bef and wBusy = 1 -> data_out = 0 immediately and stays 0 while rst = 1; release rst -> next edge gives 16'h1bef.

Source files
------------

// File: rtl/data_selector.sv
// Slot-based nibble selector: each output bus is the XOR of four slots, each slot picking one
// element from wData or wRegs0..7. Define DATA_SELECTOR_OUTREG_EN to register data_out (with wBusy hold).
module data_selector #(
    parameter int DATA_WIDTH               = 4,
    parameter int MAIN_INPUTS              = 16,
    parameter int REGS_INPUTS              = 64,
    parameter int REGS_BITS_PER_INPUT      = 32,
    parameter int SELECTOR_OUTPUTS         = 4,
    parameter int SELECTOR_OUTPUTS_PER_BUS = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          wBusy,
    input  logic [($clog2(REGS_INPUTS) + $clog2(MAIN_INPUTS) + 1)
                  * SELECTOR_OUTPUTS * SELECTOR_OUTPUTS_PER_BUS - 1:0] wSelec,
    input  logic [MAIN_INPUTS*DATA_WIDTH-1:0]             wData,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs0,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs1,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs2,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs3,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs4,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs5,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs6,
    input  logic [REGS_BITS_PER_INPUT-1:0]                wRegs7,
    output logic [SELECTOR_OUTPUTS*DATA_WIDTH-1:0]        data_out
);

    localparam int MAIN_IDX_W = $clog2(MAIN_INPUTS);
    localparam int REG_IDX_W  = $clog2(REGS_INPUTS);
    localparam int SLOT_W     = REG_IDX_W + MAIN_IDX_W + 1;
    localparam int NUM_SLOTS  = SELECTOR_OUTPUTS * SELECTOR_OUTPUTS_PER_BUS;
    localparam int OUT_W      = SELECTOR_OUTPUTS * DATA_WIDTH;

    // wRegs0 sits at the bottom so reg element r lands at flat offset r*DATA_WIDTH.
    logic [8*REGS_BITS_PER_INPUT-1:0] regsFlat;
    assign regsFlat = {wRegs7, wRegs6, wRegs5, wRegs4, wRegs3, wRegs2, wRegs1, wRegs0};

    // Stage p0: slot decode and per-bus XOR reduction
    logic [OUT_W-1:0]      busXor_p0;
    logic [SLOT_W-1:0]     field;
    logic [MAIN_IDX_W-1:0] mainIdx;
    logic [REG_IDX_W-1:0]  regIdx;
    logic [DATA_WIDTH-1:0] slotVal;

    always_comb begin
        busXor_p0 = '0;
        field     = '0;
        mainIdx   = '0;
        regIdx    = '0;
        slotVal   = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            field   = wSelec[s*SLOT_W +: SLOT_W];
            mainIdx = field[MAIN_IDX_W:1];
            regIdx  = field[SLOT_W-1 -: REG_IDX_W];
            if (field[0]) begin
                slotVal = regsFlat[regIdx*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                slotVal = wData[mainIdx*DATA_WIDTH +: DATA_WIDTH];
            end
            busXor_p0[(s/SELECTOR_OUTPUTS_PER_BUS)*DATA_WIDTH +: DATA_WIDTH] ^= slotVal;
        end
    end

`ifdef DATA_SELECTOR_OUTREG_EN
    // Stage p1: output register, frozen while wBusy
    logic [OUT_W-1:0] dataOut_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut_p1 <= '0;
        end else if (!wBusy) begin
            dataOut_p1 <= busXor_p0;
        end
    end

    assign data_out = dataOut_p1;
`else
    // Clock and wBusy have no role in the combinational build.
    logic unusedCtrl;
    assign unusedCtrl = &{1'b0, clk, wBusy};

    assign data_out = rst ? '0 : busXor_p0;
`endif

endmodule

// Fixed-parameter variant with the default geometry.
module data_selectorSynth (
    input  logic          clk,
    input  logic          rst,
    input  logic          wBusy,
    input  logic [175:0]  wSelec,
    input  logic [63:0]   wData,
    input  logic [31:0]   wRegs0,
    input  logic [31:0]   wRegs1,
    input  logic [31:0]   wRegs2,
    input  logic [31:0]   wRegs3,
    input  logic [31:0]   wRegs4,
    input  logic [31:0]   wRegs5,
    input  logic [31:0]   wRegs6,
    input  logic [31:0]   wRegs7,
    output logic [15:0]   data_out
);

    data_selector uCore (
        .clk      (clk),
        .rst      (rst),
        .wBusy    (wBusy),
        .wSelec   (wSelec),
        .wData    (wData),
        .wRegs0   (wRegs0),
        .wRegs1   (wRegs1),
        .wRegs2   (wRegs2),
        .wRegs3   (wRegs3),
        .wRegs4   (wRegs4),
        .wRegs5   (wRegs5),
        .wRegs6   (wRegs6),
        .wRegs7   (wRegs7),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_data_selector.sv
// Bench for data_selector; expectations adapt to whether DATA_SELECTOR_OUTREG_EN is defined.
module tb_data_selector;

    localparam logic [63:0]  COMMON_DATA = 64'h0123456789abcdef;
    localparam logic [255:0] COMMON_REGS =
        256'h6789abcd_f0123456_789abcde_f0123456_789abcde_f0123456_789abcde_f6012345;

    logic         clk = 1'b0;
    logic         rst;
    logic         wBusy;
    logic [175:0] wSelec;
    logic [63:0]  wData;
    logic [31:0]  wRegs0, wRegs1, wRegs2, wRegs3, wRegs4, wRegs5, wRegs6, wRegs7;
    logic [15:0]  data_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] expQ[$];

    data_selector dut (
        .clk      (clk),
        .rst      (rst),
        .wBusy    (wBusy),
        .wSelec   (wSelec),
        .wData    (wData),
        .wRegs0   (wRegs0),
        .wRegs1   (wRegs1),
        .wRegs2   (wRegs2),
        .wRegs3   (wRegs3),
        .wRegs4   (wRegs4),
        .wRegs5   (wRegs5),
        .wRegs6   (wRegs6),
        .wRegs7   (wRegs7),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [10:0] mainSlot(input int idx);
        logic [3:0] i4;
        i4 = idx[3:0];
        return {6'd0, i4, 1'b0};
    endfunction

    function automatic logic [10:0] regSlot(input int idx);
        logic [5:0] i6;
        i6 = idx[5:0];
        return {i6, 4'd0, 1'b1};
    endfunction

    // Reference: element lookup by shifting, regs taken from the wRegs0-first concatenation.
    function automatic logic [15:0] model(input logic [175:0] sel, input logic [63:0] d,
                                          input logic [255:0] regsCat);
        logic [15:0]  r;
        logic [10:0]  f;
        logic [255:0] tmpR;
        logic [63:0]  tmpD;
        int           ri;
        int           mi;
        r = '0;
        for (int s = 0; s < 16; s++) begin
            f = sel[11*s +: 11];
            if (f[0]) begin
                ri   = int'(f[10:5]);
                tmpR = regsCat >> (256 - 32*(ri/8) - 32 + 4*(ri%8));
                r[4*(s/4) +: 4] = r[4*(s/4) +: 4] ^ tmpR[3:0];
            end else begin
                mi   = int'(f[4:1]);
                tmpD = d >> (4*mi);
                r[4*(s/4) +: 4] = r[4*(s/4) +: 4] ^ tmpD[3:0];
            end
        end
        return r;
    endfunction

    task automatic setRegs(input logic [255:0] cat);
        {wRegs0, wRegs1, wRegs2, wRegs3, wRegs4, wRegs5, wRegs6, wRegs7} = cat;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: data_out=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expectAfterEdge(input string tag);
        logic [15:0] exp;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, data_out=%h expected=<none>", tag, data_out);
        end else begin
            exp = expQ.pop_front();
            check(tag, data_out, exp);
        end
    endtask

    task automatic applyPattern027();
        logic [10:0] slots[16];
        int mains[4];
        mains = '{0, 1, 4, 14};
        for (int s = 0; s < 16; s++) slots[s] = mainSlot(15);
        for (int k = 0; k < 4; k++) slots[4*k] = mainSlot(mains[k]);
        for (int s = 0; s < 16; s++) wSelec[11*s +: 11] = slots[s];
    endtask

    initial begin
        logic [10:0] slots[16];
        int regsIdx[4];
        logic [255:0] rCat;

        rst    = 1'b1;
        wBusy  = 1'b0;
        wSelec = '0;
        wData  = COMMON_DATA;
        setRegs(COMMON_REGS);
        #1;
        check("reset_initial", data_out, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", data_out, 16'h0000);
        rst = 1'b0;

        // Main-origin selection
        applyPattern027();
        expQ.push_back(16'h1bef);
        expectAfterEdge("main_select");

        // Register-origin selection
        regsIdx = '{0, 8, 63, 56};
        for (int s = 0; s < 16; s++) slots[s] = mainSlot(15);
        for (int k = 0; k < 4; k++) slots[4*k] = regSlot(regsIdx[k]);
        for (int s = 0; s < 16; s++) wSelec[11*s +: 11] = slots[s];
        expQ.push_back(16'h5f6d);
        expectAfterEdge("reg_select");

        // Identity selection cancels within each bus
        for (int s = 0; s < 16; s++) wSelec[11*s +: 11] = mainSlot(s);
        expQ.push_back(16'h0000);
        expectAfterEdge("identity_select");

        // Random selections and data against the reference
        for (int n = 0; n < 6; n++) begin
            wData = {$urandom(), $urandom()};
            rCat  = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            setRegs(rCat);
            for (int s = 0; s < 16; s++) wSelec[11*s +: 11] = 11'($urandom_range(0, 2047));
            expQ.push_back(model(wSelec, wData, rCat));
            expectAfterEdge("random_select");
        end
        wData = COMMON_DATA;
        setRegs(COMMON_REGS);

        // Busy hold then release
        applyPattern027();
        expQ.push_back(16'h1bef);
        expectAfterEdge("busy_setup");
        wBusy = 1'b1;
        wData = '0;
`ifdef DATA_SELECTOR_OUTREG_EN
        expQ.push_back(16'h1bef);
        expQ.push_back(16'h1bef);
`else
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
`endif
        expectAfterEdge("busy_hold_1");
        expectAfterEdge("busy_hold_2");
        wBusy = 1'b0;
        expQ.push_back(16'h0000);
        expectAfterEdge("busy_release");

        // Asynchronous reset while busy
        wData = COMMON_DATA;
        applyPattern027();
        expQ.push_back(16'h1bef);
        expectAfterEdge("rst_setup");
        wBusy = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_clear", data_out, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_held_busy", data_out, 16'h0000);
        wBusy = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held_idle", data_out, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
`ifdef DATA_SELECTOR_OUTREG_EN
        check("rst_release_before_edge", data_out, 16'h0000);
`else
        check("rst_release_before_edge", data_out, 16'h1bef);
`endif
        expQ.push_back(16'h1bef);
        expectAfterEdge("rst_reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
